// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and default frame
// geometry, common to the TX and RX paths.
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_PRESCALE   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Clocks occupied by one complete frame on the line.
    function automatic int unsigned frame_clocks(input int unsigned prescale,
                                                 input int unsigned data_width,
                                                 input bit          parity_en);
        return prescale * (data_width + 2 + (parity_en ? 1 : 0));
    endfunction

endpackage

// File: rtl/tx_tick_counter.sv
// Bit-time timing for the UART transmitter: a tick counter running
// 0..PRESCALE-1 and a bit counter advanced once per completed bit time.
// bit_done flags the final tick of the current bit; last_bit flags that the
// bit counter sits on the final payload bit.
module tx_tick_counter
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE   = DEFAULT_PRESCALE,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic clk_based_on_prescale,
    input  logic asy_reset,
    input  logic clear,
    input  logic enable,
    output logic bit_done,
    output logic last_bit
);

    localparam int unsigned TICK_W = (PRESCALE   > 1) ? $clog2(PRESCALE)   : 1;
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_WIDTH - 1);

    logic [TICK_W-1:0] tick;
    logic [BIT_W-1:0]  bit_cnt;

    // End-of-bit and end-of-payload flags decoded from the counters.
    always_comb begin
        bit_done = enable && (tick == TICK_MAX);
        last_bit = (bit_cnt == BIT_MAX);
    end

    // Tick counter wraps on each bit boundary; bit counter steps there too.
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            tick    <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            tick    <= '0;
            bit_cnt <= '0;
        end else if (enable) begin
            if (tick == TICK_MAX) begin
                tick    <= '0;
                bit_cnt <= bit_cnt + BIT_W'(1);
            end else begin
                tick    <= tick + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: accepts one word over valid/ready and sends start bit,
// DATA_WIDTH data bits LSB first, optional parity bit and one stop bit, each
// held PRESCALE clocks. tx_out is registered from the current state, so the
// line lags the state machine by one clock.
// Build option: define UART_TX_PARITY_EN to add the par_typ port and a
// parity bit (par_typ 0 = even, 1 = odd) after the data bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned PRESCALE   = DEFAULT_PRESCALE
) (
    input  logic                  clk_based_on_prescale,
    input  logic                  asy_reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  tx_ready,
`ifdef UART_TX_PARITY_EN
    input  logic                  par_typ,
`endif
    output logic                  tx_out,
    output logic                  busy
);

    tx_state_e state;
    tx_state_e state_next;

    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  accept;
    logic                  cnt_clear;
    logic                  cnt_enable;
    logic                  bit_done;
    logic                  last_bit;
`ifdef UART_TX_PARITY_EN
    logic                  parity_bit;
`endif

    tx_tick_counter #(
        .PRESCALE   (PRESCALE),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_tick_counter (
        .clk_based_on_prescale (clk_based_on_prescale),
        .asy_reset             (asy_reset),
        .clear                 (cnt_clear),
        .enable                (cnt_enable),
        .bit_done              (bit_done),
        .last_bit              (last_bit)
    );

    // State register.
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and counter control.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        tx_ready   = 1'b0;
        busy       = 1'b1;
        cnt_enable = 1'b1;
        cnt_clear  = 1'b0;

        case (state)
            IDLE: begin
                tx_ready   = 1'b1;
                busy       = 1'b0;
                cnt_enable = 1'b0;
                cnt_clear  = 1'b1;
                if (data_valid) begin
                    accept     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done && last_bit) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Every state starts its bit timing from zero.
        if (state_next != state) begin
            cnt_clear = 1'b1;
        end
    end

    // Payload shift register: loaded on transfer, shifted at each data bit end.
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            shift_reg <= '0;
        end else if (accept) begin
            shift_reg <= data_in;
        end else if ((state == DATA) && bit_done) begin
            shift_reg <= shift_reg >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Parity of the accepted word, computed once while the whole word is visible.
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            parity_bit <= 1'b0;
        end else if (accept) begin
            parity_bit <= (^data_in) ^ par_typ;
        end
    end
`endif

    // Registered serial line, driven from the current state.
    always_ff @(posedge clk_based_on_prescale or negedge asy_reset) begin
        if (!asy_reset) begin
            tx_out <= 1'b1;
        end else begin
            case (state)
                IDLE:    tx_out <= 1'b1;
                START:   tx_out <= 1'b0;
                DATA:    tx_out <= shift_reg[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  tx_out <= parity_bit;
`endif
                STOP:    tx_out <= 1'b1;
                default: tx_out <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: frame-level reference model compared every
// clock, plus a mid-bit sampling receiver that decodes each frame.
module tb_uart_tx_frame;

    localparam int W = 8;
    localparam int P = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = W + 3;
`else
    localparam int NB = W + 2;
`endif
    localparam int F = P * NB;

    logic         clk = 1'b0;
    logic         asy_reset = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;
    logic         par_typ = 1'b0;
    logic         tx_ready;
    logic         tx_out;
    logic         busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(
        .DATA_WIDTH (W),
        .PRESCALE   (P)
    ) dut (
        .clk_based_on_prescale (clk),
        .asy_reset             (asy_reset),
        .data_in               (data_in),
        .data_valid            (data_valid),
        .tx_ready              (tx_ready),
`ifdef UART_TX_PARITY_EN
        .par_typ               (par_typ),
`endif
        .tx_out                (tx_out),
        .busy                  (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected line bits of a frame, index 0 = start bit.
    function automatic logic [NB-1:0] expected_frame(input logic [W-1:0] w, input logic pt);
        logic [NB-1:0] f;
        f = '0;
        f[0] = 1'b0;
        for (int k = 0; k < W; k++) f[1+k] = w[k];
`ifdef UART_TX_PARITY_EN
        f[W+1] = (^w) ^ pt;
`endif
        f[NB-1] = 1'b1;
        return f;
    endfunction

    // Reference model: frame accepted at edge a keeps busy for cycles a..a+F-1
    // and puts frame bit k on the line during cycles a+1+k*P .. a+(k+1)*P.
    int            edge_n = 0;
    bit            m_active = 1'b0;
    int            m_start = 0;
    logic [NB-1:0] m_bits = '0;

    always @(posedge clk) begin
        int c_prev;
        bit rdy;
        c_prev = edge_n;
        edge_n++;
        rdy = !(m_active && (c_prev >= m_start) && (c_prev < m_start + F));
        if (!asy_reset) begin
            m_active = 1'b0;
        end else if (data_valid && rdy) begin
            m_active = 1'b1;
            m_start  = edge_n;
            m_bits   = expected_frame(data_in, par_typ);
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        int c;
        logic eb;
        logic et;
        c = edge_n;
        if (!asy_reset) begin
            eb = 1'b0;
            et = 1'b1;
        end else begin
            eb = m_active && (c >= m_start) && (c < m_start + F);
            et = (m_active && (c >= m_start + 1) && (c <= m_start + F)) ?
                 m_bits[(c - m_start - 1) / P] : 1'b1;
        end
        check("model_busy", busy, eb);
        check("model_tx_ready", tx_ready, !eb);
        check("model_tx_out", tx_out, et);
    end

    // Send one word from idle, optionally pulse data_valid mid-frame, and
    // decode the line by sampling the middle of each bit.
    task automatic send_frame(input logic [W-1:0] w, input logic pt,
                              input int pulse_at, input logic [W-1:0] pulse_w,
                              output logic [NB-1:0] fb, output int bcnt);
        int low_at;
        int nb;
        bit done;
        fb = '0;
        bcnt = 0;
        low_at = -1;
        nb = 0;
        done = 1'b0;
        @(negedge clk);
        data_in = w;
        par_typ = pt;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        for (int n = 0; n < 4 * F; n++) begin
            if (busy) bcnt++;
            if (low_at < 0 && tx_out == 1'b0) low_at = n;
            if (low_at >= 0 && nb < NB && n == low_at + P / 2 + nb * P) begin
                fb[nb] = tx_out;
                nb++;
            end
            if (n > 0 && !busy && nb == NB) begin
                done = 1'b1;
                break;
            end
            if (n == pulse_at) begin
                data_valid = 1'b1;
                data_in = pulse_w;
            end else begin
                data_valid = 1'b0;
                data_in = W'($urandom);
            end
            @(negedge clk);
        end
        data_valid = 1'b0;
        if (!done) check("frame_completed_in_budget", 32'd0, 32'd1);
    endtask

    initial begin
        logic [NB-1:0] fb;
        int            bcnt;
        int            gap;
        int            n;
        logic [W-1:0]  w;
        logic          pt;

        repeat (3) @(negedge clk);
        #2 asy_reset = 1'b1;
        @(negedge clk);
        check("reset_tx_out", tx_out, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_tx_ready", tx_ready, 1'b1);

        // 0xA5: literal line pattern and frame length.
        send_frame(8'hA5, 1'b0, -1, '0, fb, bcnt);
`ifdef UART_TX_PARITY_EN
        check("a5_even_frame", fb, 11'b10_1010_0101_0);
        check("a5_busy_clocks", bcnt, 88);
        send_frame(8'hA5, 1'b1, -1, '0, fb, bcnt);
        check("a5_odd_frame", fb, 11'b11_1010_0101_0);
        check("a5_odd_busy_clocks", bcnt, 88);
`else
        check("a5_frame", fb, 10'b11_0100_1010);
        check("a5_busy_clocks", bcnt, 80);
`endif

        // data_valid held across two words: exactly one idle clock between frames.
        @(negedge clk);
        data_in = 8'h3C;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'hC3;
        gap = 0;
        n = 0;
        while (busy && n < 4 * F) begin @(negedge clk); n++; end
        while (!busy && n < 4 * F) begin gap++; @(negedge clk); n++; end
        data_valid = 1'b0;
        check("back_to_back_idle_gap", gap, 1);
        while (busy && n < 4 * F) begin @(negedge clk); n++; end
        check("back_to_back_finished", n < 4 * F, 1'b1);
        repeat (3) @(negedge clk);
        check("back_to_back_no_third_frame", busy, 1'b0);

        // 0xFF pulsed while busy must be ignored.
        send_frame(8'h5A, 1'b0, 20, 8'hFF, fb, bcnt);
        check("pulse_ignored_frame", fb, expected_frame(8'h5A, 1'b0));
        check("pulse_ignored_busy_clocks", bcnt, F);

        // Loopback decode of edge-case words.
        send_frame(8'h00, 1'b0, -1, '0, fb, bcnt);
        check("loopback_00", fb[W:1], 8'h00);
        send_frame(8'hFF, 1'b1, -1, '0, fb, bcnt);
        check("loopback_ff", fb[W:1], 8'hFF);
        send_frame(8'h55, 1'b0, -1, '0, fb, bcnt);
        check("loopback_55", fb[W:1], 8'h55);
        check("loopback_55_stop", fb[NB-1], 1'b1);

        // Reset mid-DATA aborts the frame immediately.
        @(negedge clk);
        data_in = 8'h96;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        repeat (30) @(negedge clk);
        #2 asy_reset = 1'b0;
        #1;
        check("midframe_reset_tx_out", tx_out, 1'b1);
        check("midframe_reset_busy", busy, 1'b0);
        check("midframe_reset_tx_ready", tx_ready, 1'b1);
        repeat (2) @(negedge clk);
        #2 asy_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Randomised words, gaps and mid-frame valid pulses.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 5)) begin
                @(negedge clk);
                data_in = W'($urandom);
            end
            w  = W'($urandom);
            pt = 1'($urandom_range(0, 1));
            send_frame(w, pt, ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, F - 3)) : -1,
                       W'($urandom), fb, bcnt);
            check("random_frame", fb, expected_frame(w, pt));
        end

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
